// File: rtl/sayac_trf_sb_pkg.sv
// Shared constants and helpers for the SAYAC register file and scoreboard.
package sayac_trf_sb_pkg;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned NREGS_DEF  = 16;
    localparam int unsigned NRD_DEF    = 2;
    localparam int unsigned FLAG_W_DEF = 8;

    // Address width needed to select one of n registers.
    function automatic int unsigned sayac_aw(input int unsigned n);
        int unsigned w;
        w = 0;
        for (int unsigned i = 0; i < 31; i++) begin
            if ((32'd1 << i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/sayac_trf_sb_flag.sv
// Flag bank with a per-bit write mask.
module sayac_flag_reg #(
    parameter int unsigned FLAG_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flag_en,
    input  logic [FLAG_W-1:0] flag_mask,
    input  logic [FLAG_W-1:0] flag_in,
    output logic [FLAG_W-1:0] flag_out
);

    logic [FLAG_W-1:0] flag_q;
    logic [FLAG_W-1:0] flag_d;

    // Masked bits take the new value, the rest hold.
    always_comb begin
        flag_d = flag_q;
        if (flag_en) begin
            flag_d = (flag_q & ~flag_mask) | (flag_in & flag_mask);
        end
    end

    // Flag state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flag_q <= '0;
        end else begin
            flag_q <= flag_d;
        end
    end

    assign flag_out = flag_q;

endmodule

// File: rtl/sayac_trf_sb.sv
// Register file with pending-write scoreboard and flag bank.
// Optional macro SAYAC_TRF_BYPASS_EN adds same-cycle writeback forwarding.
module sayac_trf_sb
    import sayac_trf_sb_pkg::*;
#(
    parameter  int unsigned DATA_W = DATA_W_DEF,
    parameter  int unsigned NREGS  = NREGS_DEF,
    parameter  int unsigned NRD    = NRD_DEF,
    parameter  int unsigned FLAG_W = FLAG_W_DEF,
    localparam int unsigned AW     = sayac_aw(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NRD*AW-1:0]     rs,
    output logic [NRD*DATA_W-1:0] p,
    output logic [NRD-1:0]        rs_busy,
    input  logic                  wb_en,
    input  logic [AW-1:0]         wb_rd,
    input  logic [DATA_W-1:0]     wb_data,
    input  logic                  iss_en,
    input  logic [AW-1:0]         iss_rd,
    input  logic                  sb_flush,
    output logic [NREGS-1:0]      busy_vec,
    input  logic                  flag_en,
    input  logic [FLAG_W-1:0]     flag_mask,
    input  logic [FLAG_W-1:0]     flag_in,
    output logic [FLAG_W-1:0]     flag_out
);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [NREGS-1:0]  busy_q;
    logic [NREGS-1:0]  busy_d;

    // Register storage; r0 is never written so it stays zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_en && (wb_rd != '0)) begin
            regs_q[wb_rd] <= wb_data;
        end
    end

    // Scoreboard next state: flush beats everything, issue beats writeback.
    always_comb begin
        busy_d = busy_q;
        if (sb_flush) begin
            busy_d = '0;
        end else begin
            if (wb_en) begin
                busy_d[wb_rd] = 1'b0;
            end
            if (iss_en && (iss_rd != '0)) begin
                busy_d[iss_rd] = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
    end

    // Scoreboard state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

    // Combinational read ports.
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] addr;
        logic          zero;
        assign addr = rs[k*AW +: AW];
        assign zero = (addr == '0);
`ifdef SAYAC_TRF_BYPASS_EN
        logic hit;
        assign hit = wb_en && (wb_rd == addr) && !zero;
        assign p[k*DATA_W +: DATA_W] = zero ? '0 : (hit ? wb_data : regs_q[addr]);
        assign rs_busy[k] = !zero && !hit && busy_q[addr];
`else
        assign p[k*DATA_W +: DATA_W] = zero ? '0 : regs_q[addr];
        assign rs_busy[k] = !zero && busy_q[addr];
`endif
    end

    sayac_flag_reg #(
        .FLAG_W(FLAG_W)
    ) u_flag (
        .clk      (clk),
        .rst      (rst),
        .flag_en  (flag_en),
        .flag_mask(flag_mask),
        .flag_in  (flag_in),
        .flag_out (flag_out)
    );

endmodule

// File: tb/tb_sayac_trf_sb.sv
// Self-checking bench for sayac_trf_sb: directed steps plus random traffic
// against an array-based reference model.
module tb_sayac_trf_sb;

    logic        clk;
    logic        rst;
    logic [7:0]  rs;
    logic [31:0] p;
    logic [1:0]  rs_busy;
    logic        wb_en;
    logic [3:0]  wb_rd;
    logic [15:0] wb_data;
    logic        iss_en;
    logic [3:0]  iss_rd;
    logic        sb_flush;
    logic [15:0] busy_vec;
    logic        flag_en;
    logic [7:0]  flag_mask;
    logic [7:0]  flag_in;
    logic [7:0]  flag_out;

    int total;
    int bad;

    logic [15:0] m_regs [16];
    bit          m_busy [16];
    logic [7:0]  m_flag;

`ifdef SAYAC_TRF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    sayac_trf_sb dut (
        .clk      (clk),
        .rst      (rst),
        .rs       (rs),
        .p        (p),
        .rs_busy  (rs_busy),
        .wb_en    (wb_en),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .iss_en   (iss_en),
        .iss_rd   (iss_rd),
        .sb_flush (sb_flush),
        .busy_vec (busy_vec),
        .flag_en  (flag_en),
        .flag_mask(flag_mask),
        .flag_in  (flag_in),
        .flag_out (flag_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
        m_flag = '0;
    endtask

    function automatic logic [15:0] m_busy_vec();
        logic [15:0] v;
        for (int i = 0; i < 16; i++) v[i] = m_busy[i];
        return v;
    endfunction

    // Expected read data and busy for one address given current inputs.
    task automatic check_reads();
        logic [3:0]  a;
        logic [15:0] ed;
        logic        eb;
        for (int k = 0; k < 2; k++) begin
            a = rs[k*4 +: 4];
            if (a == 0) begin
                ed = '0;
                eb = 1'b0;
            end else if (BYP && wb_en && wb_rd == a) begin
                ed = wb_data;
                eb = 1'b0;
            end else begin
                ed = m_regs[a];
                eb = m_busy[a];
            end
            chk($sformatf("p%0d[r%0d]", k, a), 32'(p[k*16 +: 16]), 32'(ed));
            chk($sformatf("rs_busy%0d[r%0d]", k, a), 32'(rs_busy[k]), 32'(eb));
        end
    endtask

    // Apply the edge rules to the model.
    task automatic model_edge();
        if (wb_en && wb_rd != 0) m_regs[wb_rd] = wb_data;
        if (sb_flush) begin
            for (int i = 0; i < 16; i++) m_busy[i] = 1'b0;
        end else begin
            if (wb_en) m_busy[wb_rd] = 1'b0;
            if (iss_en && iss_rd != 0) m_busy[iss_rd] = 1'b1;
        end
        if (flag_en) begin
            for (int j = 0; j < 8; j++) if (flag_mask[j]) m_flag[j] = flag_in[j];
        end
    endtask

    task automatic step();
        #1;
        check_reads();
        @(posedge clk);
        model_edge();
        #1;
        chk("busy_vec", 32'(busy_vec), 32'(m_busy_vec()));
        chk("flag_out", 32'(flag_out), 32'(m_flag));
    endtask

    task automatic idle();
        wb_en = 0; iss_en = 0; sb_flush = 0; flag_en = 0;
        wb_rd = 0; iss_rd = 0; wb_data = 0; flag_mask = 0; flag_in = 0;
    endtask

    initial begin
        total = 0;
        bad = 0;
        model_clear();
        idle();
        rs = 8'h00;
        rst = 1'b0;
        #2;
        chk("reset_busy", 32'(busy_vec), 32'h0);
        chk("reset_flag", 32'(flag_out), 32'h0);
        #10;
        rst = 1'b1;

        // All registers read zero after reset.
        for (int r = 0; r < 16; r++) begin
            rs = {4'(r), 4'(15 - r)};
            step();
            chk("post_reset_p", p, 32'h0);
        end

        // Write r5, read it back; r0 ignores writes.
        wb_en = 1; wb_rd = 4'd5; wb_data = 16'hBEEF; rs = 8'h00;
        step();
        idle(); rs = 8'h50;
        step();
        chk("r5_port1", 32'(p[31:16]), 32'hBEEF);
        wb_en = 1; wb_rd = 4'd0; wb_data = 16'h1234; rs = 8'h00;
        step();
        idle();
        step();
        chk("r0_zero", p, 32'h0);

        // Issue r7, writeback two cycles later.
        iss_en = 1; iss_rd = 4'd7; rs = 8'h77;
        step();
        idle(); rs = 8'h77;
        step();
        chk("r7_busy_a", 32'(rs_busy), 32'h3);
        wb_en = 1; wb_rd = 4'd7; wb_data = 16'h00AA;
        #1;
        chk("r7_busy_b", 32'(rs_busy), BYP ? 32'h0 : 32'h3);
        step();
        idle();
        step();
        chk("r7_free", 32'(rs_busy), 32'h0);
        chk("r7_data", p, 32'h00AA_00AA);
        iss_en = 1; iss_rd = 4'd7; wb_en = 1; wb_rd = 4'd7; wb_data = 16'h0BBB;
        step();
        chk("r7_iss_wins", 32'(busy_vec[7]), 32'h1);
        idle();
        wb_en = 1; wb_rd = 4'd7; wb_data = 16'h0CCC;
        step();
        idle();

        // Same-cycle write and read of r3.
        wb_en = 1; wb_rd = 4'd3; wb_data = 16'h5555; rs = 8'h03;
        #1;
        chk("r3_bypass", 32'(p[15:0]), BYP ? 32'h5555 : 32'h0);
        step();
        idle();
        step();
        chk("r3_after", 32'(p[15:0]), 32'h5555);

        // Flag mask behaviour.
        flag_en = 1; flag_mask = 8'h0F; flag_in = 8'hFF;
        step();
        chk("flag_lo", 32'(flag_out), 32'h0F);
        flag_mask = 8'hF0; flag_in = 8'h00;
        step();
        chk("flag_hi", 32'(flag_out), 32'h0F);
        flag_en = 0; flag_mask = 8'hFF; flag_in = 8'hAA;
        step();
        chk("flag_hold", 32'(flag_out), 32'h0F);
        idle();

        // Flush with a coincident issue and writeback.
        iss_en = 1; iss_rd = 4'd2; step();
        iss_rd = 4'd4; step();
        iss_rd = 4'd9; step();
        chk("pre_flush", 32'(busy_vec), 32'h0214);
        iss_rd = 4'd6; sb_flush = 1; wb_en = 1; wb_rd = 4'd2; wb_data = 16'h7777;
        step();
        chk("flush", 32'(busy_vec), 32'h0);
        idle(); rs = 8'h02;
        step();
        chk("flush_wb_data", 32'(p[15:0]), 32'h7777);

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            rs        = 8'($urandom);
            wb_en     = 1'($urandom_range(0, 1));
            wb_rd     = 4'($urandom);
            wb_data   = 16'($urandom);
            iss_en    = 1'($urandom_range(0, 1));
            iss_rd    = 4'($urandom);
            sb_flush  = ($urandom_range(0, 15) == 0);
            flag_en   = 1'($urandom_range(0, 1));
            flag_mask = 8'($urandom);
            flag_in   = 8'($urandom);
            step();
        end

        // Asynchronous reset mid-stream with strobes active.
        wb_en = 1; wb_rd = 4'd5; wb_data = 16'hDEAD; iss_en = 1; iss_rd = 4'd5;
        flag_en = 1; flag_mask = 8'hFF; flag_in = 8'hFF; rs = 8'h5A;
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy_vec), 32'h0);
        chk("mid_rst_flag", 32'(flag_out), 32'h0);
        chk("mid_rst_p", p, 32'h0);
        model_clear();
        @(posedge clk);
        #1;
        chk("rst_hold_busy", 32'(busy_vec), 32'h0);
        idle();
        rst = 1'b1;
        rs = 8'h5A;
        step();
        chk("after_rst_p", p, 32'h0);
        for (int n = 0; n < 50; n++) begin
            rs = 8'($urandom); wb_en = 1'($urandom_range(0, 1)); wb_rd = 4'($urandom);
            wb_data = 16'($urandom); iss_en = 1'($urandom_range(0, 1)); iss_rd = 4'($urandom);
            sb_flush = 0; flag_en = 1'($urandom_range(0, 1));
            flag_mask = 8'($urandom); flag_in = 8'($urandom);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sayac_trf_sb.md
SAYAC_TRF_SB -- requirements
Module: sayac_trf_sb

Interface
REQ-001 Parameter DATA_W, default 16, register and write-data width.
REQ-002 Parameter NREGS, default 16, register count (power of two, >= 2); AW = log2(NREGS).
REQ-003 Parameter NRD, default 2, number of independent read ports.
REQ-004 Parameter FLAG_W, default 8, flag register width.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 rs  input  NRD*AW  read addresses; port k uses bits [k*AW +: AW].
REQ-008 p  output  NRD*DATA_W  read data; port k uses bits [k*DATA_W +: DATA_W].
REQ-009 rs_busy  output  NRD  port k's source register has a pending write.
REQ-010 wb_en  input  1  writeback strobe.
REQ-011 wb_rd  input  AW  writeback destination.
REQ-012 wb_data  input  DATA_W  writeback data.
REQ-013 iss_en  input  1  issue strobe; marks a destination pending.
REQ-014 iss_rd  input  AW  issued destination.
REQ-015 sb_flush  input  1  clears all pending marks.
REQ-016 busy_vec  output  NREGS  per-register pending bits.
REQ-017 flag_en  input  1  flag update strobe.
REQ-018 flag_mask  input  FLAG_W  per-bit flag write enable.
REQ-019 flag_in  input  FLAG_W  new flag values.
REQ-020 flag_out  output  FLAG_W  registered flags.

Function
REQ-021 Register 0 SHALL read as zero on every port, SHALL ignore writebacks and SHALL never be marked busy.
REQ-022 Reads SHALL be combinational: p[k] = regs[rs[k]], with zero latency from rs to p.
REQ-023 When wb_en=1 and wb_rd!=0, regs[wb_rd] SHALL take wb_data at the next rising edge.
REQ-024 When iss_en=1 and iss_rd!=0, busy_vec[iss_rd] SHALL set at the next edge.
REQ-025 When wb_en=1, busy_vec[wb_rd] SHALL clear at the next edge, unless REQ-026 applies.
REQ-026 When issue and writeback target the same register in one cycle, busy SHALL remain set, because the newer issue wins.
REQ-027 When sb_flush=1, all busy bits SHALL clear at the next edge; a coincident issue SHALL be ignored and a coincident writeback SHALL still write data.
REQ-028 rs_busy[k] SHALL equal busy_vec[rs[k]] combinationally, and SHALL be 0 for rs[k]=0.
REQ-029 For each bit j, flag_out[j] SHALL take flag_in[j] at the edge when flag_en=1 and flag_mask[j]=1; otherwise it SHALL hold.
REQ-030 Writeback to a register that is not busy SHALL be legal: data is written and busy stays 0.

Reset
REQ-031 rst=0 SHALL, asynchronously: set all NREGS registers to 0, all busy bits to 0 and flag_out to 0.
REQ-032 Deassertion of rst SHALL be released on a clock edge; the first update SHALL occur at the first rising edge with rst=1.
REQ-033 Reset asserted mid-operation SHALL discard in-flight writebacks, issues and flag updates for that cycle.

Configuration
REQ-034 Macro SAYAC_TRF_BYPASS_EN, when defined, SHALL add write-to-read forwarding: if wb_en=1, wb_rd=rs[k] and rs[k]!=0, then p[k]=wb_data and rs_busy[k]=0 in the same cycle.
REQ-035 Without SAYAC_TRF_BYPASS_EN, a same-cycle read of the register being written SHALL return the old value, with rs_busy per REQ-028.

Structure
REQ-036 A shared package SHALL hold the default parameter constants and the function deriving AW from NREGS.
REQ-037 The flag bank SHALL be one sub-module, sayac_flag_reg (parameter FLAG_W), with a per-bit mask enable.

Verification
REQ-038 Reset, then read r0..r15 on both ports -> all p=0, busy_vec=0, flag_out=0x00.
REQ-039 Write 0xBEEF to r5, then read r5 on port 1 the next cycle -> p[1]=0xBEEF; a write of 0x1234 to r0 -> r0 still reads 0.
REQ-040 Issue r7, then writeback r7 0x00AA two cycles later -> rs_busy=1 for 2 cycles, then 0; a simultaneous issue r7 and writeback r7 -> busy_vec[7] stays 1.
REQ-041 Same-cycle wb r3=0x5555 and read r3 -> p=0x5555 with SAYAC_TRF_BYPASS_EN defined; p=old value (0) without it.
REQ-042 Flags 0x00, then flag_en=1, mask=0x0F, in=0xFF -> 0x0F; then mask=0xF0, in=0x00 -> 0x0F; then flag_en=0 -> hold.
REQ-043 Issue r2, r4 and r9, then sb_flush with a coincident issue r6 -> busy_vec=0; rst pulse mid-stream -> all state 0 immediately.
